// File: rtl/aesl_deadlock_watchdog_if.sv
// Report channel of the deadlock watchdog: one-shot valid/ready handshake plus
// the payload captured when the deadlock is declared.
interface aesl_deadlock_watchdog_if #(
    parameter int AXIS_W = 14
);
    logic              report_valid;
    logic              report_ready;
    logic [7:0]        first_mon_idx;
    logic [AXIS_W-1:0] axis_snapshot;

    modport master (
        output report_valid,
        output first_mon_idx,
        output axis_snapshot,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  first_mon_idx,
        input  axis_snapshot,
        output report_ready
    );
endinterface

// File: rtl/aesl_deadlock_watchdog.sv
// Counts consecutive cycles with any monitor blocked and declares a sticky
// deadlock after THRESHOLD cycles, presenting a single report to the bench.
module aesl_deadlock_watchdog #(
    parameter int NUM_MON   = 4,
    parameter int AXIS_W    = 14,
    parameter int THRESHOLD = 1000,
    parameter int CNT_W     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MON-1:0]        mon_block,
    input  logic [AXIS_W-1:0]         axis_block_sigs,
    input  logic                      all_idle,
    input  logic                      clear,
    output logic                      suspect,
    output logic                      deadlock,
    output logic [CNT_W-1:0]          blocked_cycles,
    aesl_deadlock_watchdog_if.master  rpt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WATCH  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        idx_q, idx_d;
    logic [AXIS_W-1:0] snap_q, snap_d;
    logic              deadlock_q, deadlock_d;
    logic              suspect_q, suspect_d;
    logic              valid_q, valid_d;

    logic              any_block;
    logic [7:0]        lowest_idx;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  cnt_sat;

    assign any_block = |mon_block;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    // After declaration the counter keeps running but must not wrap.
    assign cnt_sat   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_inc;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        lowest_idx = 8'd0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (mon_block[i]) begin
                lowest_idx = 8'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        deadlock_d = deadlock_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (any_block) begin
                    cnt_d = CNT_W'(1);
                    idx_d = lowest_idx;
                    if (THRESHOLD == 1) begin
                        state_d    = ST_REPORT;
                        deadlock_d = 1'b1;
                        snap_d     = axis_block_sigs;
                    end else begin
                        state_d = ST_WATCH;
                    end
                end
            end
            ST_WATCH: begin
                // all_idle wins over a still-asserted block.
                if (all_idle || !any_block) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == THR) begin
                        state_d    = ST_REPORT;
                        deadlock_d = 1'b1;
                        snap_d     = axis_block_sigs;
                    end
                end
            end
            ST_REPORT: begin
                if (any_block) begin
                    cnt_d = cnt_sat;
                end
                if (rpt.report_ready) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (any_block) begin
                    cnt_d = cnt_sat;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // clear beats every transition, including a same-cycle declaration.
        if (clear) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            snap_d     = '0;
            deadlock_d = 1'b0;
        end

        suspect_d = (state_d == ST_WATCH);
        valid_d   = (state_d == ST_REPORT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            deadlock_q <= 1'b0;
            suspect_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            deadlock_q <= deadlock_d;
            suspect_q  <= suspect_d;
            valid_q    <= valid_d;
        end
    end

    assign suspect           = suspect_q;
    assign deadlock          = deadlock_q;
    assign blocked_cycles    = cnt_q;
    assign rpt.report_valid  = valid_q;
    assign rpt.first_mon_idx = idx_q;
    assign rpt.axis_snapshot = snap_q;

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// Directed bench: one watchdog with THRESHOLD=8 and one with THRESHOLD=1.
module tb_aesl_deadlock_watchdog;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [3:0]  mon8 = '0;
    logic [13:0] axis8 = '0;
    logic        idle8 = 1'b0;
    logic        clear8 = 1'b0;
    logic        suspect8;
    logic        deadlock8;
    logic [15:0] bc8;

    logic [3:0]  mon1 = '0;
    logic [13:0] axis1 = '0;
    logic        idle1 = 1'b0;
    logic        clear1 = 1'b0;
    logic        suspect1;
    logic        deadlock1;
    logic [15:0] bc1;

    int tests_run = 0;
    int tests_failed = 0;

    aesl_deadlock_watchdog_if #(.AXIS_W(14)) if8 ();
    aesl_deadlock_watchdog_if #(.AXIS_W(14)) if1 ();

    aesl_deadlock_watchdog #(.NUM_MON(4), .AXIS_W(14), .THRESHOLD(8), .CNT_W(16)) dut8 (
        .clock(clock), .reset(reset), .mon_block(mon8), .axis_block_sigs(axis8),
        .all_idle(idle8), .clear(clear8), .suspect(suspect8), .deadlock(deadlock8),
        .blocked_cycles(bc8), .rpt(if8.master)
    );

    aesl_deadlock_watchdog #(.NUM_MON(4), .AXIS_W(14), .THRESHOLD(1), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .mon_block(mon1), .axis_block_sigs(axis1),
        .all_idle(idle1), .clear(clear1), .suspect(suspect1), .deadlock(deadlock1),
        .blocked_cycles(bc1), .rpt(if1.master)
    );

    always #5 clock = ~clock;

    // Outputs are sampled 1 time unit after the edge; inputs set then apply to the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_dut8();
        mon8 = '0; idle8 = 1'b0; if8.report_ready = 1'b0;
        clear8 = 1'b1;
        tick();
        clear8 = 1'b0;
        tests_run++;
        if (deadlock8 !== 1'b0 || bc8 !== 16'd0 || if8.report_valid !== 1'b0 || suspect8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_all got dl=%0b bc=%0d v=%0b s=%0b want 0 0 0 0", deadlock8, bc8, if8.report_valid, suspect8);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests_run++;
        if (suspect8 !== 1'b0 || deadlock8 !== 1'b0 || bc8 !== 16'd0 || if8.report_valid !== 1'b0
            || if8.first_mon_idx !== 8'd0 || if8.axis_snapshot !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset8 got s=%0b dl=%0b bc=%0d v=%0b idx=%0d snap=%0h want all 0",
                     suspect8, deadlock8, bc8, if8.report_valid, if8.first_mon_idx, if8.axis_snapshot);
        end
        tests_run++;
        if (suspect1 !== 1'b0 || deadlock1 !== 1'b0 || bc1 !== 16'd0 || if1.report_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset1 got s=%0b dl=%0b bc=%0d v=%0b want all 0", suspect1, deadlock1, bc1, if1.report_valid);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_declare();
        mon8 = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests_run++;
            if (suspect8 !== (k < 8) || bc8 !== 16'(k) || deadlock8 !== (k == 8) || if8.report_valid !== (k == 8)) begin
                tests_failed++;
                $display("FAIL declare_k%0d got s=%0b bc=%0d dl=%0b v=%0b want s=%0b bc=%0d dl=%0b v=%0b",
                         k, suspect8, bc8, deadlock8, if8.report_valid, (k < 8), k, (k == 8), (k == 8));
            end
        end
        tests_run++;
        if (if8.first_mon_idx !== 8'd2) begin
            tests_failed++;
            $display("FAIL declare_idx got %0d want 2", if8.first_mon_idx);
        end
        if8.report_ready = 1'b1;
        tick();
        if8.report_ready = 1'b0;
        tests_run++;
        if (if8.report_valid !== 1'b0 || deadlock8 !== 1'b1 || bc8 !== 16'd9) begin
            tests_failed++;
            $display("FAIL declare_handshake got v=%0b dl=%0b bc=%0d want v=0 dl=1 bc=9", if8.report_valid, deadlock8, bc8);
        end
        clear_dut8();
        $display("[TB] test_declare done");
    endtask

    task automatic test_restart();
        mon8 = 4'b0001;
        repeat (7) tick();
        tests_run++;
        if (bc8 !== 16'd7 || deadlock8 !== 1'b0 || suspect8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_burst1 got bc=%0d dl=%0b s=%0b want bc=7 dl=0 s=1", bc8, deadlock8, suspect8);
        end
        mon8 = 4'b0000;
        tick();
        tests_run++;
        if (bc8 !== 16'd0 || suspect8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_gap got bc=%0d s=%0b want bc=0 s=0", bc8, suspect8);
        end
        mon8 = 4'b0001;
        repeat (7) tick();
        tests_run++;
        if (bc8 !== 16'd7 || deadlock8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_burst2_7 got bc=%0d dl=%0b want bc=7 dl=0", bc8, deadlock8);
        end
        tick();
        tests_run++;
        if (bc8 !== 16'd8 || deadlock8 !== 1'b1 || if8.report_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_burst2_8 got bc=%0d dl=%0b v=%0b want bc=8 dl=1 v=1", bc8, deadlock8, if8.report_valid);
        end
        clear_dut8();
        $display("[TB] test_restart done");
    endtask

    task automatic test_all_idle();
        mon8 = 4'b0010;
        repeat (5) tick();
        idle8 = 1'b1;
        tick();
        idle8 = 1'b0;
        mon8 = 4'b0000;
        tests_run++;
        if (bc8 !== 16'd0 || suspect8 !== 1'b0 || if8.report_valid !== 1'b0 || if8.first_mon_idx !== 8'd1) begin
            tests_failed++;
            $display("FAIL all_idle got bc=%0d s=%0b v=%0b idx=%0d want bc=0 s=0 v=0 idx=1",
                     bc8, suspect8, if8.report_valid, if8.first_mon_idx);
        end
        repeat (4) tick();
        tests_run++;
        if (deadlock8 !== 1'b0 || if8.report_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL all_idle_noreport got dl=%0b v=%0b want 0 0", deadlock8, if8.report_valid);
        end
        clear_dut8();
        $display("[TB] test_all_idle done");
    endtask

    task automatic test_snapshot();
        int hi;
        mon8 = 4'b1000;
        axis8 = 14'h2A5;
        repeat (8) tick();
        axis8 = 14'h1111;
        hi = (if8.report_valid === 1'b1) ? 1 : 0;
        for (int k = 2; k <= 20; k++) begin
            tick();
            if (if8.report_valid === 1'b1) hi++;
        end
        tests_run++;
        if (hi != 20) begin
            tests_failed++;
            $display("FAIL snap_valid_cycles got %0d want 20", hi);
        end
        tests_run++;
        if (if8.axis_snapshot !== 14'h2A5 || if8.first_mon_idx !== 8'd3 || bc8 !== 16'd27) begin
            tests_failed++;
            $display("FAIL snap_frozen got snap=%0h idx=%0d bc=%0d want snap=2a5 idx=3 bc=27",
                     if8.axis_snapshot, if8.first_mon_idx, bc8);
        end
        if8.report_ready = 1'b1;
        tick();
        if8.report_ready = 1'b0;
        mon8 = 4'b0000;
        tests_run++;
        if (if8.report_valid !== 1'b0 || deadlock8 !== 1'b1 || bc8 !== 16'd28) begin
            tests_failed++;
            $display("FAIL snap_handshake got v=%0b dl=%0b bc=%0d want v=0 dl=1 bc=28", if8.report_valid, deadlock8, bc8);
        end
        repeat (3) tick();
        tests_run++;
        if (bc8 !== 16'd28 || deadlock8 !== 1'b1 || if8.axis_snapshot !== 14'h2A5 || if8.report_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_halt_hold got bc=%0d dl=%0b snap=%0h v=%0b want bc=28 dl=1 snap=2a5 v=0",
                     bc8, deadlock8, if8.axis_snapshot, if8.report_valid);
        end
        axis8 = '0;
        clear_dut8();
        $display("[TB] test_snapshot done");
    endtask

    task automatic test_clear_on_declare();
        mon8 = 4'b0001;
        repeat (7) tick();
        clear8 = 1'b1;
        tick();
        clear8 = 1'b0;
        mon8 = 4'b0000;
        tests_run++;
        if (deadlock8 !== 1'b0 || if8.report_valid !== 1'b0 || bc8 !== 16'd0 || suspect8 !== 1'b0 || if8.first_mon_idx !== 8'd0) begin
            tests_failed++;
            $display("FAIL clear_on_declare got dl=%0b v=%0b bc=%0d s=%0b idx=%0d want all 0",
                     deadlock8, if8.report_valid, bc8, suspect8, if8.first_mon_idx);
        end
        tick();
        tests_run++;
        if (if8.report_valid !== 1'b0 || deadlock8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_on_declare_after got v=%0b dl=%0b want 0 0", if8.report_valid, deadlock8);
        end
        $display("[TB] test_clear_on_declare done");
    endtask

    task automatic test_back_to_back();
        if8.report_ready = 1'b1;
        mon8 = 4'b0001;
        repeat (8) tick();
        tests_run++;
        if (if8.report_valid !== 1'b1 || deadlock8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_held_decl got v=%0b dl=%0b want 1 1", if8.report_valid, deadlock8);
        end
        tick();
        tests_run++;
        if (if8.report_valid !== 1'b0 || deadlock8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_held_pulse got v=%0b dl=%0b want 0 1", if8.report_valid, deadlock8);
        end
        repeat (3) tick();
        tests_run++;
        if (if8.report_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_held_once got v=%0b want 0", if8.report_valid);
        end
        clear_dut8();
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_threshold1();
        mon1 = 4'b1001;
        tick();
        mon1 = 4'b0000;
        tests_run++;
        if (deadlock1 !== 1'b1 || if1.report_valid !== 1'b1 || if1.first_mon_idx !== 8'd0 || bc1 !== 16'd1 || suspect1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL thr1_declare got dl=%0b v=%0b idx=%0d bc=%0d s=%0b want dl=1 v=1 idx=0 bc=1 s=0",
                     deadlock1, if1.report_valid, if1.first_mon_idx, bc1, suspect1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (deadlock1 !== 1'b0 || if1.report_valid !== 1'b0 || bc1 !== 16'd0 || if1.first_mon_idx !== 8'd0 || if1.axis_snapshot !== 14'd0) begin
            tests_failed++;
            $display("FAIL thr1_reset got dl=%0b v=%0b bc=%0d idx=%0d snap=%0h want all 0",
                     deadlock1, if1.report_valid, bc1, if1.first_mon_idx, if1.axis_snapshot);
        end
        repeat (2) tick();
        tests_run++;
        if (if1.report_valid !== 1'b0 || deadlock1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL thr1_noreissue got v=%0b dl=%0b want 0 0", if1.report_valid, deadlock1);
        end
        $display("[TB] test_threshold1 done");
    endtask

    initial begin
        if8.report_ready = 1'b0;
        if1.report_ready = 1'b0;
        test_reset();
        test_declare();
        test_restart();
        test_all_idle();
        test_snapshot();
        test_clear_on_declare();
        test_back_to_back();
        test_threshold1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
